// File: rtl/bid_mem_arbiter_pkg.sv
// Shared definitions for the two-requester banked memory arbiter.
//  - FSM state encoding
//  - one-hot bank select constants ADDR_A..ADDR_E
//  - idx2onehot(): bank index to one-hot select, 0 for an out-of-range index
package bid_mem_arbiter_pkg;

  localparam int unsigned IdxW = 3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWr   = 3'd1,
    StRd0  = 3'd2,
    StRd1  = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [4:0] ADDR_A = 5'b00001;
  localparam logic [4:0] ADDR_B = 5'b00010;
  localparam logic [4:0] ADDR_C = 5'b00100;
  localparam logic [4:0] ADDR_D = 5'b01000;
  localparam logic [4:0] ADDR_E = 5'b10000;

  function automatic logic [4:0] idx2onehot(input logic [IdxW-1:0] idx);
    case (idx)
      3'd0:    return ADDR_A;
      3'd1:    return ADDR_B;
      3'd2:    return ADDR_C;
      3'd3:    return ADDR_D;
      3'd4:    return ADDR_E;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/bid_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//  clk_i, rst_i          clock, synchronous active-high reset
//  req_a_i, req_b_i      requests
//  enable_i              arbitrate only when 1 (controller idle)
//  gnt_a_o, gnt_b_o      combinational grants, at most one high
// Holds last_grant; after reset B counts as last, so A wins the first tie.
module bid_mem_arbiter_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic enable_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q, last_b_d;

  always_comb begin
    gnt_a_o  = enable_i & req_a_i & (~req_b_i | last_b_q);
    gnt_b_o  = enable_i & req_b_i & (~req_a_i | ~last_b_q);
    last_b_d = last_b_q;
    if (gnt_a_o || gnt_b_o) begin
      last_b_d = gnt_b_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/bid_mem_arbiter.sv
// Shares one five-bank one-hot addressed memory with a tristate data bus between
// requesters A and B. Round-robin, one access in flight, one-cycle ack.
//  clk, rst                               clock, synchronous active-high reset
//  req_x/we_x/idx_x/wdata_x (x = a, b)    request, held stable until ack_x
//  ack_x/rdata_x/err_x                    completion pulse, read data, range error
//  mem_addr/mem_wr/mem_rd                 memory control pins, 0 when idle
//  mem_data                               bidirectional bus, driven only in WR
module bid_mem_arbiter
  import bid_mem_arbiter_pkg::*;
#(
  parameter int unsigned A_WID  = 5,
  parameter int unsigned D_WID  = 8,
  parameter int unsigned N_BANK = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [IdxW-1:0]  idx_a,
  input  logic [D_WID-1:0] wdata_a,
  output logic             ack_a,
  output logic [D_WID-1:0] rdata_a,
  output logic             err_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [IdxW-1:0]  idx_b,
  input  logic [D_WID-1:0] wdata_b,
  output logic             ack_b,
  output logic [D_WID-1:0] rdata_b,
  output logic             err_b,
  output logic [A_WID-1:0] mem_addr,
  output logic             mem_wr,
  output logic             mem_rd,
  inout  wire  [D_WID-1:0] mem_data
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;  // 0 = A, 1 = B
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [D_WID-1:0] wdata_q, wdata_d;
  logic [D_WID-1:0] rdata_q, rdata_d;

  logic             gnt_a, gnt_b, arb_en;
  logic             sel_we, sel_bad;
  logic [IdxW-1:0]  sel_idx;
  logic [D_WID-1:0] sel_wdata;
  logic             in_wr, in_rd, in_done;

  assign arb_en = (state_q == StIdle);

  bid_mem_arbiter_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .enable_i (arb_en),
    .gnt_a_o  (gnt_a),
    .gnt_b_o  (gnt_b)
  );

  always_comb begin
    sel_we    = gnt_b ? we_b    : we_a;
    sel_idx   = gnt_b ? idx_b   : idx_a;
    sel_wdata = gnt_b ? wdata_b : wdata_a;
    sel_bad   = (32'(sel_idx) >= N_BANK);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_a || gnt_b) begin
          owner_d = gnt_b;
          we_d    = sel_we;
          idx_d   = sel_idx;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = sel_bad;
          // An error spends the WR slot with every pin suppressed, so error and
          // write acks share the same latency.
          state_d = (sel_bad || sel_we) ? StWr : StRd0;
        end
      end
      StWr:  state_d = StDone;
      StRd0: state_d = StRd1;
      StRd1: begin
        rdata_d = mem_data;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_wr    = (state_q == StWr) && !err_q;
    in_rd    = (state_q == StRd0) || (state_q == StRd1);
    in_done  = (state_q == StDone);
    mem_wr   = in_wr;
    mem_rd   = in_rd;
    mem_addr = (in_wr || in_rd) ? A_WID'(idx2onehot(idx_q)) : '0;
    ack_a    = in_done && !owner_q;
    ack_b    = in_done && owner_q;
    err_a    = ack_a && err_q;
    err_b    = ack_b && err_q;
    rdata_a  = (ack_a && !err_q) ? rdata_q : '0;
    rdata_b  = (ack_b && !err_q) ? rdata_q : '0;
  end

  // WR is only reachable from IDLE, where mem_rd is 0, so the bus always
  // has a released cycle before the controller drives it.
  assign mem_data = in_wr ? wdata_q : {D_WID{1'bz}};

  logic unused_we;
  assign unused_we = we_q;

endmodule
